// File: rtl/sdram_stream_reader_if.sv
// SDRAM arbiter master-port bundle for sdram_stream_reader.
// master = bus initiator, slave = arbiter/controller side.
interface sdram_stream_reader_if;
  logic        bus_request;
  logic [25:0] bus_addr;
  logic        bus_write;
  logic        bus_burst;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_rdvalid;
  logic        bus_complete;

  modport master (
    output bus_request, bus_addr, bus_write,
    output bus_burst, bus_byte_enable, bus_wdata,
    input  bus_ack, bus_rdata, bus_rdvalid,
    input  bus_complete
  );

  modport slave (
    input  bus_request, bus_addr, bus_write,
    input  bus_burst, bus_byte_enable, bus_wdata,
    output bus_ack, bus_rdata, bus_rdvalid,
    output bus_complete
  );
endinterface

// File: rtl/sdram_stream_reader.sv
// Read-only SDRAM streamer: bursts/singles into a local FIFO.
// Optional counters: define SDRAM_STREAM_STATS_EN.
module sdram_stream_reader #(
  parameter int FIFO_DEPTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] base_addr,
  input  logic [19:0] length,
  output logic        busy,
  output logic        done,
  sdram_stream_reader_if.master bus,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [15:0] stat_bursts,
  output logic [15:0] stat_stall
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] cnt_t;
  localparam cnt_t DEPTH_W = cnt_t'(FIFO_DEPTH);
  localparam cnt_t BURST_W = cnt_t'(BURST_LEN);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_SPACE = 2'd1;
  localparam logic [1:0] REQ        = 2'd2;
  localparam logic [1:0] WAIT_DATA  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [25:0] cur_addr_q, cur_addr_d;
  logic [19:0] remaining_q, remaining_d;
  cnt_t        reserved_q, reserved_d;
  logic        req_q, req_d;
  logic [25:0] addr_q, addr_d;
  logic        burst_q, burst_d;
  logic        done_q, done_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  cnt_t          count_q;

  cnt_t        n;
  logic [19:0] txn_w;
  logic        fits, push, pop, issue, accept;

  always_comb begin
    n      = (remaining_q >= 20'(BURST_LEN)) ? BURST_W : cnt_t'(1);
    fits   = (DEPTH_W - reserved_q) >= n;
    push   = (state_q == WAIT_DATA) && bus.bus_rdvalid;
    pop    = out_valid && out_ready;
    issue  = (state_q == WAIT_SPACE) && fits;
    accept = (state_q == IDLE) && start;
    txn_w  = burst_q ? 20'(BURST_LEN) : 20'd1;

    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    req_d       = req_q;
    addr_d      = addr_q;
    burst_d     = burst_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        cur_addr_d  = base_addr & ~26'h3;
        remaining_d = length;
        if (length == 20'd0) done_d  = 1'b1;
        else                 state_d = WAIT_SPACE;
      end
      WAIT_SPACE: if (fits) begin
        addr_d  = cur_addr_q;
        burst_d = (n == BURST_W);
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.bus_ack) begin
        req_d       = 1'b0;
        cur_addr_d  = cur_addr_q + 26'({txn_w, 2'b00});
        remaining_d = remaining_q - txn_w;
        state_d     = WAIT_DATA;
      end
      default: if (bus.bus_rdvalid && bus.bus_complete) begin
        if (remaining_q == 20'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_SPACE;
        end
      end
    endcase

    // space is claimed at issue and released only when the consumer pops
    reserved_d = reserved_q + (issue ? n : cnt_t'(0))
               - cnt_t'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      reserved_q  <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      burst_q     <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      reserved_q  <= reserved_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      done_q      <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= bus.bus_rdata;
  end

`ifdef SDRAM_STREAM_STATS_EN
  logic [15:0] bursts_q, stall_q;

  always_ff @(posedge clock) begin
    if (reset || accept) begin
      bursts_q <= '0;
      stall_q  <= '0;
    end else begin
      if (state_q == REQ && bus.bus_ack && burst_q
          && bursts_q != 16'hFFFF)
        bursts_q <= bursts_q + 16'd1;
      if (state_q == WAIT_SPACE && !fits
          && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_stall  = stall_q;
`else
  assign stat_bursts = 16'd0;
  assign stat_stall  = 16'd0;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr_q];

  assign bus.bus_request     = req_q;
  assign bus.bus_addr        = addr_q;
  assign bus.bus_burst       = burst_q;
  assign bus.bus_write       = 1'b0;
  assign bus.bus_byte_enable = 4'hF;
  assign bus.bus_wdata       = 32'd0;
endmodule

// File: tb/tb_sdram_stream_reader.sv
// Randomized bench for sdram_stream_reader with an SDRAM
// responder and a word-stream/transaction reference model.
module tb_sdram_stream_reader;
  logic        clock;
  logic        reset;
  logic        start;
  logic [25:0] base_addr;
  logic [19:0] length;
  logic        busy, done;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [15:0] stat_bursts, stat_stall;

  sdram_stream_reader_if bus();

  sdram_stream_reader dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bus(bus),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .stat_bursts(stat_bursts), .stat_stall(stat_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [25:0] exp_ta[$];
  bit          exp_tb[$];

  bit rst_req, start_req, chk_drop, req_seen;
  int ready_mode, ack_fixed, job_len;
  int cyc, cmp_cyc, done_cnt, txn_cnt;

  int          sl_phase, sl_delay, sl_lat, sl_k, sl_words, sl_sent;
  logic [25:0] sl_addr;
  logic        sl_burst;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [25:0] a);
    return ({6'd0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic step();
    logic [25:0] ea;
    bit eb;
    @(negedge clock);
    cyc++;
    if (done) begin
      done_cnt++;
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      if (job_len != 0)
        chk("done_timing", cyc, cmp_cyc + 1);
    end
    if (bus.bus_request) req_seen = 1'b1;

    reset = rst_req;
    start = start_req;
    if (rst_req)              out_ready = 1'b0;
    else if (ready_mode == 1) out_ready = 1'b1;
    else if (ready_mode == 0) out_ready = ($urandom_range(3) != 0);
    else                      out_ready = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("pop_extra", 32'd1, 32'd0);
      else chk("data", out_data, exp_q.pop_front());
    end

    bus.bus_ack = 1'b0;
    bus.bus_rdvalid = 1'b0;
    bus.bus_complete = 1'b0;
    if (chk_drop) begin
      chk("req_drop", {31'd0, bus.bus_request}, 32'd0);
      chk_drop = 1'b0;
    end
    if (sl_phase == 2) begin
      if (sl_lat > 0) sl_lat--;
      else if ($urandom_range(3) != 0) begin
        bus.bus_rdvalid = 1'b1;
        bus.bus_rdata = mem_word(sl_addr + 26'(4 * sl_k));
        bus.bus_complete = (sl_k == sl_words - 1);
        sl_k++;
        sl_sent++;
        if (bus.bus_complete) begin
          sl_phase = 0;
          cmp_cyc = cyc;
        end
      end
    end else begin
      if (sl_phase == 0 && bus.bus_request) begin
        sl_addr  = bus.bus_addr;
        sl_burst = bus.bus_burst;
        sl_delay = (ack_fixed >= 0) ? ack_fixed : $urandom_range(5);
        sl_phase = 1;
      end
      if (sl_phase == 1) begin
        chk("req_hold", {31'd0, bus.bus_request}, 32'd1);
        chk("addr_hold", {6'd0, bus.bus_addr}, {6'd0, sl_addr});
        chk("burst_hold", {31'd0, bus.bus_burst}, {31'd0, sl_burst});
        if (sl_delay == 0) begin
          bus.bus_ack = 1'b1;
          txn_cnt++;
          chk("ctl_const",
              {bus.bus_write, bus.bus_byte_enable, bus.bus_wdata[26:0]},
              {1'b0, 4'hF, 27'd0});
          if (exp_ta.size() == 0) chk("txn_extra", 32'd1, 32'd0);
          else begin
            ea = exp_ta.pop_front();
            eb = exp_tb.pop_front();
            chk("txn_addr", {6'd0, sl_addr}, {6'd0, ea});
            chk("txn_burst", {31'd0, sl_burst}, {31'd0, eb});
          end
          sl_words = sl_burst ? 8 : 1;
          sl_k = 0;
          sl_lat = $urandom_range(3);
          sl_phase = 2;
          chk_drop = 1'b1;
        end else sl_delay--;
      end
    end
  endtask

  task automatic start_job(logic [25:0] base, int len, int mode);
    logic [25:0] a;
    int nb;
    a = base & ~26'h3;
    exp_q.delete();
    exp_ta.delete();
    exp_tb.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem_word(a + 26'(4 * i)));
    nb = len / 8;
    for (int k = 0; k < nb; k++) begin
      exp_ta.push_back(a + 26'(32 * k));
      exp_tb.push_back(1'b1);
    end
    for (int j = 0; j < len % 8; j++) begin
      exp_ta.push_back(a + 26'(4 * (nb * 8 + j)));
      exp_tb.push_back(1'b0);
    end
    base_addr = base;
    length = 20'(len);
    job_len = len;
    ready_mode = mode;
    done_cnt = 0;
    txn_cnt = 0;
    sl_sent = 0;
    req_seen = 1'b0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    chk("busy_after_start", {31'd0, busy}, {31'd0, len != 0});
    if (len == 0) chk("done_len0", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_job(int len);
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      step();
      fin = (done_cnt > 0 && exp_q.size() == 0 && sl_phase == 0);
    end
    chk("job_finish", {31'd0, fin}, 32'd1);
    repeat (4) step();
    chk("done_count", done_cnt, 1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("txn_left", exp_ta.size(), 0);
    chk("txn_total", txn_cnt, len / 8 + len % 8);
    if (len == 0) chk("no_req_len0", {31'd0, req_seen}, 32'd0);
`ifdef SDRAM_STREAM_STATS_EN
    chk("stat_bursts", {16'd0, stat_bursts}, len / 8);
`else
    chk("stat_zero", {stat_bursts, stat_stall}, 32'd0);
`endif
  endtask

  task automatic run_job(logic [25:0] base, int len, int mode);
    start_job(base, len, mode);
    finish_job(len);
  endtask

  initial begin
    logic [25:0] rb;
    bit bad_v, bad_r;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b0;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    bus.bus_rdvalid = 1'b0;
    bus.bus_complete = 1'b0;
    rst_req = 1'b1;
    start_req = 1'b0;
    chk_drop = 1'b0;
    ready_mode = 1;
    ack_fixed = -1;
    job_len = 0;
    cyc = 0;
    cmp_cyc = 0;
    sl_phase = 0;
    step();
    step();
    rst_req = 1'b0;
    step();
    chk("rst_ctl", {busy, done, bus.bus_request, bus.bus_burst, out_valid},
        5'd0);
    chk("rst_addr", {6'd0, bus.bus_addr}, 32'd0);
    chk("rst_stats", {stat_bursts, stat_stall}, 32'd0);

    run_job(26'h100, 16, 1);
    run_job(26'h200, 11, 1);
    run_job(26'h40, 0, 1);
    ack_fixed = 5;
    run_job(26'h1000, 20, 0);
    ack_fixed = -1;

    start_job(26'h8000, 64, 2);
    repeat (300) step();
    chk("stall_txns", txn_cnt, 4);
    chk("stall_req", {31'd0, bus.bus_request}, 32'd0);
`ifdef SDRAM_STREAM_STATS_EN
    chk("stall_cnt", {31'd0, stat_stall != 16'd0}, 32'd1);
`endif
    ready_mode = 0;
    finish_job(64);

    start_job(26'h2000, 16, 2);
    for (int c = 0; c < 200 && sl_sent < 3; c++) step();
    chk("rst_mid_sent", sl_sent, 3);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    exp_q.delete();
    exp_ta.delete();
    exp_tb.delete();
    step();
    chk("mid_rst_ctl",
        {busy, done, bus.bus_request, bus.bus_burst, out_valid}, 5'd0);
    chk("mid_rst_addr", {6'd0, bus.bus_addr}, 32'd0);
    chk("mid_rst_stats", {stat_bursts, stat_stall}, 32'd0);
    bad_v = 1'b0;
    bad_r = 1'b0;
    for (int c = 0; c < 100 && sl_phase != 0; c++) begin
      step();
      if (out_valid) bad_v = 1'b1;
      if (bus.bus_request) bad_r = 1'b1;
    end
    repeat (3) step();
    chk("late_rdvalid_ignored", {31'd0, bad_v}, 32'd0);
    chk("no_req_after_rst", {31'd0, bad_r}, 32'd0);
    run_job(26'h3000, 13, 1);

    run_job(26'h3FFFFE3, 20, 0);
    for (int j = 0; j < 8; j++) begin
      rb = 26'($urandom);
      run_job(rb, $urandom_range(40), $urandom_range(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
